cdb_arbiter: RTL and testbench

Common-data-bus arbiter for the out-of-order core. It shares the single CDB among four result producers: integer ALU, multiplier, divider and load/store. It schedules multiplier write-back slots at issue time, because the pipelined multiplier cannot stall. It grants the remaining slots round-robin to the stallable units and drives the registered `cdb_*` broadcast consumed by the issue queues and the ROB.

---
 rtl/cdb_arbiter_pkg.sv | 21 ++
 rtl/cdb_arbiter_rr_arbiter3.sv | 24 ++
 rtl/cdb_arbiter.sv | 67 ++++++
 tb/tb_cdb_arbiter.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: shared CDB widths, requester ids and broadcast bundle
package cdb_arbiter_pkg;
  localparam int DATA_W = 32;
  localparam int TAG_W = 6;
  typedef enum logic [1:0] {
    REQ_INT  = 2'd0,
    REQ_DIV  = 2'd1,
    REQ_LS   = 2'd2,
    REQ_MULT = 2'd3
  } req_id_t;
  typedef struct packed {
    logic              valid;
    logic              branch;
    logic              branch_taken;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_t;
  function automatic req_id_t next_req(req_id_t r);
    return (r == REQ_INT) ? REQ_DIV : (r == REQ_DIV) ? REQ_LS : REQ_INT;
  endfunction
endpackage

// File: rtl/cdb_arbiter_rr_arbiter3.sv
// rr_arbiter3: three-way round-robin grant starting at the pointer
module rr_arbiter3
  import cdb_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  req_id_t    ptr,
  output logic [2:0] gnt,
  output req_id_t    next_ptr
);
  req_id_t idx;
  // walk int->div->ls from ptr; first requester wins, pointer moves past it
  always_comb begin
    gnt = '0;
    next_ptr = ptr;
    idx = (ptr == REQ_MULT) ? REQ_INT : ptr;
    for (int k = 0; k < 3; k++) begin
      if (req[idx] && gnt == '0) begin
        gnt[idx] = 1'b1;
        next_ptr = next_req(idx);
      end
      idx = next_req(idx);
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the CDB between pre-scheduled multiplier slots and round-robin stallable units
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int MULT_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mult_issue,
  input  logic              mult_valid,
  input  logic [DATA_W-1:0] mult_data,
  input  logic [TAG_W-1:0]  mult_tag,
  input  logic              int_req,
  input  logic [DATA_W-1:0] int_data,
  input  logic [TAG_W-1:0]  int_tag,
  input  logic              int_branch,
  input  logic              int_branch_taken,
  output logic              int_gnt,
  input  logic              div_req,
  input  logic [DATA_W-1:0] div_data,
  input  logic [TAG_W-1:0]  div_tag,
  output logic              div_gnt,
  input  logic              ls_req,
  input  logic [DATA_W-1:0] ls_data,
  input  logic [TAG_W-1:0]  ls_tag,
  output logic              ls_gnt,
  output logic [DATA_W-1:0] cdb_data,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic              cdb_valid,
  output logic              cdb_branch,
  output logic              cdb_branch_taken,
  output logic              err_mult_slot
);
  logic [MULT_LAT-1:0] resv;
  req_id_t rr, rr_next;
  logic [2:0] arb_gnt;
  cdb_t cdb_q, cdb_d;
  rr_arbiter3 u_rr (
    .req({ls_req, div_req, int_req}),
    .ptr(rr),
    .gnt(arb_gnt),
    .next_ptr(rr_next)
  );
  assign {ls_gnt, div_gnt, int_gnt} = resv[0] ? 3'b000 : arb_gnt;
  assign {cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data} = cdb_q;
  // select the slot owner's payload; only the ALU carries branch fields
  always_comb begin
    cdb_d = resv[0] ? {3'b100, mult_tag, mult_data} :
            int_gnt ? {1'b1, int_branch, int_branch_taken, int_tag, int_data} :
            div_gnt ? {3'b100, div_tag, div_data} :
            ls_gnt  ? {3'b100, ls_tag, ls_data} : '0;
  end
  // slot schedule, rr pointer, broadcast register and sticky slot-violation flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resv <= '0;
      rr <= REQ_INT;
      cdb_q <= '0;
      err_mult_slot <= 1'b0;
    end else begin
      resv <= {mult_issue, resv[MULT_LAT-1:1]};
      rr <= resv[0] ? rr : rr_next;
      cdb_q <= cdb_d;
      if (mult_valid != resv[0]) err_mult_slot <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: scoreboard bench for the CDB arbiter
module tb_cdb_arbiter;
  localparam int L = 4;
  logic clk = 0, rst = 0;
  logic mult_issue = 0, mult_valid = 0;
  logic [31:0] mult_data = 0, int_data = 0, div_data = 0, ls_data = 0;
  logic [5:0] mult_tag = 0, int_tag = 0, div_tag = 0, ls_tag = 0;
  logic int_req = 0, int_branch = 0, int_branch_taken = 0, div_req = 0, ls_req = 0;
  logic int_gnt, div_gnt, ls_gnt;
  logic [31:0] cdb_data;
  logic [5:0] cdb_tag;
  logic cdb_valid, cdb_branch, cdb_branch_taken, err_mult_slot;
  int vectors = 0, miscompares = 0, n = 0, rr_m = 0;
  logic [40:0] q[$];
  bit resv_at[int];
  logic err_m = 0, mult_drop = 0, mv_flip = 0;
  logic [7:0] mhist = 0;

  cdb_arbiter #(.MULT_LAT(L)) dut (
    .clk(clk), .rst(rst), .mult_issue(mult_issue), .mult_valid(mult_valid),
    .mult_data(mult_data), .mult_tag(mult_tag),
    .int_req(int_req), .int_data(int_data), .int_tag(int_tag), .int_branch(int_branch),
    .int_branch_taken(int_branch_taken), .int_gnt(int_gnt),
    .div_req(div_req), .div_data(div_data), .div_tag(div_tag), .div_gnt(div_gnt),
    .ls_req(ls_req), .ls_data(ls_data), .ls_tag(ls_tag), .ls_gnt(ls_gnt),
    .cdb_data(cdb_data), .cdb_tag(cdb_tag), .cdb_valid(cdb_valid), .cdb_branch(cdb_branch),
    .cdb_branch_taken(cdb_branch_taken), .err_mult_slot(err_mult_slot)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, n, got, exp);
    end
  endtask

  task automatic cycle();
    logic [2:0] rq, eg;
    logic [40:0] nx;
    logic rsv;
    int w, u;
    mult_valid = mhist[L-1] ^ mv_flip;
    mult_data = $urandom;
    mult_tag = 6'($urandom);
    @(negedge clk);
    rsv = resv_at.exists(n);
    rq = {int_req, div_req, ls_req};
    eg = 3'b000;
    w = -1;
    if (!rsv)
      for (int i = 0; i < 3; i++) begin
        u = (rr_m + i) % 3;
        if (eg == 3'b000 && rq[2-u]) begin
          eg = 3'b100 >> u;
          w = u;
        end
      end
    check("gnt", 64'({int_gnt, div_gnt, ls_gnt}), 64'(eg));
    check("cdb", 64'({cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data}), 64'(q.pop_front()));
    check("err", 64'(err_mult_slot), 64'(err_m));
    case (w)
      0: nx = {1'b1, int_branch, int_branch_taken, int_tag, int_data};
      1: nx = {3'b100, div_tag, div_data};
      2: nx = {3'b100, ls_tag, ls_data};
      default: nx = '0;
    endcase
    if (rsv) nx = {3'b100, mult_tag, mult_data};
    if (!rst) nx = '0;
    q.push_back(nx);
    if (rst) begin
      if (mult_valid != rsv) err_m = 1'b1;
      if (w >= 0) rr_m = (w + 1) % 3;
      if (mult_issue) resv_at[n + L] = 1'b1;
    end
    @(posedge clk);
    #1;
    mhist = rst ? {mhist[6:0], mult_issue && !mult_drop} : 8'h00;
    n++;
  endtask

  task automatic async_reset(int hold);
    rst = 0;
    #1;
    check("async_clr", 64'({cdb_valid, cdb_branch, cdb_branch_taken, cdb_tag, cdb_data, err_mult_slot}), 64'(0));
    resv_at.delete();
    rr_m = 0;
    err_m = 0;
    mhist = 0;
    q.delete();
    q.push_back('0);
    repeat (hold) cycle();
    rst = 1;
  endtask

  task automatic rand_payload();
    int_data = $urandom;
    div_data = $urandom;
    ls_data = $urandom;
    int_tag = 6'($urandom);
    div_tag = 6'($urandom);
    ls_tag = 6'($urandom);
    int_branch = 1'($urandom);
    int_branch_taken = 1'($urandom);
  endtask

  initial begin
    q.push_back('0);
    repeat (2) cycle();
    rst = 1;
    repeat (10) cycle();
    int_req = 1; int_data = 32'h1234_5678; int_tag = 6'd5; int_branch = 1; int_branch_taken = 1;
    cycle();
    int_req = 0; int_branch = 0; int_branch_taken = 0;
    repeat (2) cycle();
    int_req = 1; div_req = 1; ls_req = 1;
    repeat (9) begin
      rand_payload();
      cycle();
    end
    ls_req = 0;
    mult_issue = 1;
    repeat (2) cycle();
    mult_issue = 0;
    repeat (8) begin
      rand_payload();
      cycle();
    end
    mv_flip = 1;
    cycle();
    mv_flip = 0;
    repeat (5) cycle();
    mult_issue = 1; mult_drop = 1;
    cycle();
    mult_issue = 0; mult_drop = 0;
    repeat (8) cycle();
    mult_issue = 1;
    repeat (2) cycle();
    mult_issue = 0;
    cycle();
    async_reset(2);
    repeat (8) begin
      rand_payload();
      cycle();
    end
    repeat (300) begin
      rand_payload();
      {int_req, div_req, ls_req} = 3'($urandom);
      mult_issue = ($urandom_range(0, 3) == 0);
      cycle();
    end
    {int_req, div_req, ls_req, mult_issue} = '0;
    repeat (L + 2) cycle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
